// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle controller: FSM states, opcodes, mux selects.
// Pure definitions; no timing or flow control of its own.
// Imported by the interface, the ALU decoder and the controller top.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WDATA = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: IR fields and status in, mux selects and enables out.
// No storage; memory flow control is the MemReq/MemReady pair.
// master = controller, slave = datapath/memory side.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       MemReq;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       IllegalInstr;

    modport master (
        input  op, funct3, funct7b5, Zero, MemReady,
        output MemReq, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalInstr
    );

    modport slave (
        output op, funct3, funct7b5, Zero, MemReady,
        input  MemReq, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalInstr
    );
endinterface

// File: rtl/alu_decoder.sv
// Maps alu_op and funct fields to ALUControl; flags unsupported funct3 in funct mode.
// Purely combinational, zero latency.
// No flow control.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] alu_op,
    output logic [2:0] alu_control,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: illegal = 1'b1;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the shared-memory RV32I multicycle datapath.
// One state per cycle: lw 5, sw/R/I/jal 4, beq 3 cycles plus memory wait cycles.
// FETCH/MEMREAD/MEMWRITE hold until MemReady (ignored when MEM_HANDSHAKE=0).
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    multicycle_controller_if.master     bus
);

    state_t     state, next_state, cur;
    logic       ready;
    logic [1:0] alu_op;
    logic [2:0] alu_control;
    logic       alu_illegal;
    logic       mem_req, pc_write, mem_write, ir_write, reg_write, illegal;
    logic       adr_src;
    logic [1:0] result_src, src_a, src_b;

    assign ready = MEM_HANDSHAKE ? bus.MemReady : 1'b1;

    alu_decoder u_alu_decoder (
        .op5         (bus.op[5]),
        .funct3      (bus.funct3),
        .funct7b5    (bus.funct7b5),
        .alu_op      (alu_op),
        .alu_control (alu_control),
        .illegal     (alu_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    // While reset is high, selects decode as FETCH and every enable is forced low.
    always_comb begin
        cur        = reset ? FETCH : state;
        next_state = cur;
        mem_req    = 1'b0;
        pc_write   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        adr_src    = 1'b0;
        result_src = RES_ALUOUT;
        src_a      = SRCA_PC;
        src_b      = SRCB_WDATA;
        alu_op     = ALUOP_ADD;
        case (cur)
            FETCH: begin
                mem_req    = 1'b1;
                src_b      = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = ready;
                pc_write   = ready;
                if (ready) next_state = DECODE;
            end
            DECODE: begin
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
                case (bus.op)
                    OP_LOAD, OP_STORE: next_state = MEMADR;
                    OP_RTYPE:          next_state = EXECR;
                    OP_ITYPE:          next_state = EXECI;
                    OP_BRANCH:         next_state = BEQ;
                    OP_JAL:            next_state = JAL;
                    default: begin
                        next_state = FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                src_a      = SRCA_A;
                src_b      = SRCB_IMM;
                next_state = (bus.op == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (ready) next_state = MEMWB;
            end
            MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                next_state = FETCH;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (ready) next_state = FETCH;
            end
            EXECR, EXECI: begin
                src_a      = SRCA_A;
                src_b      = (cur == EXECI) ? SRCB_IMM : SRCB_WDATA;
                alu_op     = ALUOP_FUNCT;
                illegal    = alu_illegal;
                next_state = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                next_state = FETCH;
            end
            BEQ: begin
                src_a      = SRCA_A;
                alu_op     = ALUOP_SUB;
                pc_write   = bus.Zero;
                next_state = FETCH;
            end
            JAL: begin
                src_a      = SRCA_OLDPC;
                src_b      = SRCB_FOUR;
                pc_write   = 1'b1;
                next_state = ALUWB;
            end
            default: next_state = FETCH;
        endcase
    end

    assign bus.MemReq       = mem_req   & ~reset;
    assign bus.PCWrite      = pc_write  & ~reset;
    assign bus.MemWrite     = mem_write & ~reset;
    assign bus.IRWrite      = ir_write  & ~reset;
    assign bus.RegWrite     = reg_write & ~reset;
    assign bus.IllegalInstr = illegal   & ~reset;
    assign bus.AdrSrc       = adr_src;
    assign bus.ResultSrc    = result_src;
    assign bus.ALUSrcA      = src_a;
    assign bus.ALUSrcB      = src_b;
    assign bus.ALUControl   = alu_control;
    assign bus.ImmSrc       = imm_src(bus.op);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class state by state.
module tb_multicycle_controller;
    import riscv_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    multicycle_controller_if bus ();

    multicycle_controller #(.MEM_HANDSHAKE(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ck_st(input string tag, input state_t exp);
        chk(tag, 32'(dut.state), 32'(exp));
    endtask

    task automatic ck1(input string tag, input logic got, input logic exp);
        chk(tag, 32'(got), 32'(exp));
    endtask

    task automatic ck2(input string tag, input logic [2:0] got, input logic [2:0] exp);
        chk(tag, 32'(got), 32'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        #1;
    endtask

    // Starts in FETCH with MemReady=1; checks the EXEC cycle then ALUWB.
    task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input state_t ex, input logic [2:0] ctrl,
                           input logic ill);
        set_ir(op, f3, f7);
        step();
        ck_st({tag, "_decode"}, DECODE);
        step();
        ck_st({tag, "_exec"}, ex);
        ck2({tag, "_aluctl"}, bus.ALUControl, ctrl);
        ck1({tag, "_illegal"}, bus.IllegalInstr, ill);
        ck2({tag, "_srcb"}, {1'b0, bus.ALUSrcB}, (ex == EXECI) ? 3'b001 : 3'b000);
        step();
        ck_st({tag, "_aluwb"}, ALUWB);
        ck1({tag, "_regwrite"}, bus.RegWrite, 1'b1);
        step();
        ck_st({tag, "_done"}, FETCH);
    endtask

    task automatic run_beq(input string tag, input logic z);
        set_ir(OP_BRANCH, 3'b000, 1'b0);
        bus.Zero = z;
        ck2({tag, "_imm"}, {1'b0, bus.ImmSrc}, 3'b010);
        step();
        ck_st({tag, "_decode"}, DECODE);
        step();
        ck_st({tag, "_beq"}, BEQ);
        ck1({tag, "_pcwrite"}, bus.PCWrite, z);
        ck2({tag, "_aluctl"}, bus.ALUControl, 3'b001);
        step();
        ck_st({tag, "_done"}, FETCH);
        bus.Zero = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.MemReady = 1'b1;
        bus.Zero = 1'b0;
        set_ir(7'b0, 3'b0, 1'b0);
        step();
        ck1("rst_memreq", bus.MemReq, 1'b0);
        ck1("rst_irwrite", bus.IRWrite, 1'b0);
        ck1("rst_pcwrite", bus.PCWrite, 1'b0);
        step();
        ck_st("rst_state", FETCH);

        // lw, no wait states: 5 cycles
        reset = 1'b0;
        set_ir(OP_LOAD, 3'b010, 1'b0);
        ck_st("lw_fetch", FETCH);
        ck1("lw_irwrite", bus.IRWrite, 1'b1);
        ck1("lw_pcwrite", bus.PCWrite, 1'b1);
        ck2("lw_fetch_srcb", {1'b0, bus.ALUSrcB}, 3'b010);
        step();
        ck_st("lw_decode", DECODE);
        ck2("lw_decode_srca", {1'b0, bus.ALUSrcA}, 3'b001);
        ck1("lw_decode_regwrite", bus.RegWrite, 1'b0);
        step();
        ck_st("lw_memadr", MEMADR);
        ck2("lw_memadr_srca", {1'b0, bus.ALUSrcA}, 3'b010);
        step();
        ck_st("lw_memread", MEMREAD);
        ck1("lw_memread_adr", bus.AdrSrc, 1'b1);
        ck1("lw_memread_regwrite", bus.RegWrite, 1'b0);
        step();
        ck_st("lw_memwb", MEMWB);
        ck1("lw_memwb_regwrite", bus.RegWrite, 1'b1);
        ck2("lw_memwb_result", {1'b0, bus.ResultSrc}, 3'b001);
        step();
        ck_st("lw_done", FETCH);

        // sw with a stalled fetch, then 3 wait cycles in MEMWRITE
        bus.MemReady = 1'b0;
        set_ir(OP_STORE, 3'b010, 1'b0);
        ck1("sw_fetch_wait_irwrite", bus.IRWrite, 1'b0);
        step();
        ck_st("sw_fetch_hold", FETCH);
        bus.MemReady = 1'b1;
        #1;
        ck1("sw_fetch_irwrite", bus.IRWrite, 1'b1);
        step();
        ck_st("sw_decode", DECODE);
        step();
        ck_st("sw_memadr", MEMADR);
        bus.MemReady = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            ck_st("sw_memwrite_wait", MEMWRITE);
            ck1("sw_memwrite_strobe", bus.MemWrite, 1'b1);
            ck1("sw_memwrite_adr", bus.AdrSrc, 1'b1);
            ck2("sw_imm", {1'b0, bus.ImmSrc}, 3'b001);
            step();
        end
        bus.MemReady = 1'b1;
        #1;
        ck_st("sw_memwrite_last", MEMWRITE);
        ck1("sw_memwrite_last_strobe", bus.MemWrite, 1'b1);
        step();
        ck_st("sw_done", FETCH);
        ck1("sw_done_strobe", bus.MemWrite, 1'b0);

        // R/I-type ALU decode
        run_alu("sub",  OP_RTYPE, 3'b000, 1'b1, EXECR, 3'b001, 1'b0);
        run_alu("add",  OP_RTYPE, 3'b000, 1'b0, EXECR, 3'b000, 1'b0);
        run_alu("and",  OP_RTYPE, 3'b111, 1'b0, EXECR, 3'b010, 1'b0);
        run_alu("addi", OP_ITYPE, 3'b000, 1'b1, EXECI, 3'b000, 1'b0);
        run_alu("ori",  OP_ITYPE, 3'b110, 1'b0, EXECI, 3'b011, 1'b0);
        run_alu("slti", OP_ITYPE, 3'b010, 1'b0, EXECI, 3'b101, 1'b0);
        run_alu("badf3", OP_ITYPE, 3'b001, 1'b0, EXECI, 3'b000, 1'b1);

        run_beq("beq_taken", 1'b1);
        run_beq("beq_not", 1'b0);

        // jal: 4 cycles
        set_ir(OP_JAL, 3'b000, 1'b0);
        ck2("jal_imm", {1'b0, bus.ImmSrc}, 3'b011);
        step();
        ck_st("jal_decode", DECODE);
        step();
        ck_st("jal_jal", JAL);
        ck1("jal_pcwrite", bus.PCWrite, 1'b1);
        ck2("jal_srca", {1'b0, bus.ALUSrcA}, 3'b001);
        ck2("jal_srcb", {1'b0, bus.ALUSrcB}, 3'b010);
        step();
        ck_st("jal_aluwb", ALUWB);
        ck1("jal_regwrite", bus.RegWrite, 1'b1);
        step();
        ck_st("jal_done", FETCH);

        // unsupported opcode
        set_ir(7'b1111111, 3'b000, 1'b0);
        step();
        ck_st("ill_decode", DECODE);
        ck1("ill_pulse", bus.IllegalInstr, 1'b1);
        ck1("ill_regwrite", bus.RegWrite, 1'b0);
        ck1("ill_memwrite", bus.MemWrite, 1'b0);
        step();
        ck_st("ill_next", FETCH);
        ck1("ill_pulse_end", bus.IllegalInstr, 1'b0);

        // reset mid-store aborts the access
        set_ir(OP_STORE, 3'b010, 1'b0);
        step();
        step();
        bus.MemReady = 1'b0;
        step();
        ck_st("rstmid_memwrite", MEMWRITE);
        ck1("rstmid_strobe", bus.MemWrite, 1'b1);
        reset = 1'b1;
        step();
        ck_st("rstmid_state", FETCH);
        ck1("rstmid_strobe_drop", bus.MemWrite, 1'b0);
        reset = 1'b0;
        bus.MemReady = 1'b1;
        #1;
        ck1("rstmid_refetch", bus.MemReq, 1'b1);
        ck1("rstmid_no_write", bus.MemWrite, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
